rbb_result_packer: RTL and testbench

//  Sits directly upstream of the result batch buffer: takes narrow result words from a PE array,

---
 rtl/rbb_pkg.sv | 43 ++++
 rtl/rbb_line_assembler.sv | 86 ++++++++
 rtl/rbb_result_packer.sv | 181 ++++++++++++++++++
 tb/tb_rbb_result_packer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbb_pkg
// Description : Shared constants for the result batch buffer packer: default
//               geometry, trailer line field layout and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rbb_pkg;

    // Default buffer geometry
    localparam int c_DEF_ADDR_WIDTH = 8;
    localparam int c_DEF_DATA_WIDTH = 512;
    localparam int c_DEF_RES_WIDTH  = 64;

    // Line count and words-per-line derived from a given geometry
    function automatic int rbbNumLines(input int addrWidth);
        return 1 << addrWidth;
    endfunction

    function automatic int rbbWpl(input int dataWidth, input int resWidth);
        return dataWidth / resWidth;
    endfunction

    localparam int c_NUM_LINES = rbbNumLines(c_DEF_ADDR_WIDTH);
    localparam int c_WPL       = rbbWpl(c_DEF_DATA_WIDTH, c_DEF_RES_WIDTH);

    // Trailer line layout
    localparam int c_LINES_LSB = 0;
    localparam int c_LINES_W   = 16;
    localparam int c_CNT_LSB   = 16;
    localparam int c_CNT_W     = 32;
    localparam int c_SPLIT_BIT = 48;

    // FSM state encoding
    localparam int                 c_STATE_W       = 3;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_DRAIN = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_FILL       = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_TRAILER    = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DONE       = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_FULL  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rbb_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : rbb_line_assembler
// Description : Collects result words into lanes of one buffer line. Emits a
//               completion strobe on the accept that closes the line and a
//               registered line (upper lanes zero on a short last line).
// Revision    : 1.0 - initial release
// ============================================================================
module rbb_line_assembler #(
    parameter int RBB_DATA_WIDTH = 512,
    parameter int RES_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_accept,
    input  logic [RES_WIDTH-1:0]      i_resData,
    input  logic                      i_resLast,
    output logic                      o_lineComplete,
    output logic                      o_lineValid,
    output logic [RBB_DATA_WIDTH-1:0] o_lineData
);

    localparam int                  c_WPL       = RBB_DATA_WIDTH / RES_WIDTH;
    localparam int                  c_LANE_W    = $clog2(c_WPL);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_WPL - 1);

    logic [c_LANE_W-1:0]       r_laneIdx;
    logic [RBB_DATA_WIDTH-1:0] w_line;
    logic                      r_lineValid;
    logic [RBB_DATA_WIDTH-1:0] r_lineData;

    // A line closes when its last lane fills or when the batch's last word arrives
    assign o_lineComplete = i_accept && ((r_laneIdx == c_LAST_LANE) || i_resLast);

    generate
        for (genvar l = 0; l < c_WPL; l++) begin : g_lane
            localparam logic [c_LANE_W-1:0] c_LANE = c_LANE_W'(l);
            logic [RES_WIDTH-1:0] r_lane;

            // Lane storage; emptied whenever a line leaves so the next line starts zeroed
            always_ff @(posedge clk) begin
                if (rst || i_clear || o_lineComplete) begin
                    r_lane <= '0;
                end else if (i_accept && (r_laneIdx == c_LANE)) begin
                    r_lane <= i_resData;
                end
            end

            // Assembled view: the incoming word bypasses into its lane, lanes above a last word read zero
            assign w_line[l*RES_WIDTH +: RES_WIDTH] =
                (i_accept && (r_laneIdx == c_LANE)) ? i_resData :
                (i_resLast && (c_LANE > r_laneIdx)) ? {RES_WIDTH{1'b0}} : r_lane;
        end
        if (c_WPL * RES_WIDTH < RBB_DATA_WIDTH) begin : g_pad
            assign w_line[RBB_DATA_WIDTH-1:c_WPL*RES_WIDTH] = '0;
        end
    endgenerate

    // Lane counter: advance per accepted word, wrap to lane 0 when a line closes
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_laneIdx <= '0;
        end else if (i_accept) begin
            r_laneIdx <= o_lineComplete ? '0 : r_laneIdx + c_LANE_W'(1);
        end
    end

    // Completed line register feeding the buffer write one cycle after closure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lineValid <= 1'b0;
            r_lineData  <= '0;
        end else begin
            r_lineValid <= o_lineComplete && !i_clear;
            if (o_lineComplete) begin
                r_lineData <= w_line;
            end
        end
    end

    assign o_lineValid = r_lineValid;
    assign o_lineData  = r_lineData;

endmodule
`default_nettype wire

// File: rtl/rbb_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : rbb_result_packer
// Description : Packs PE-array result words into result batch buffer lines,
//               closes each batch with a trailer line at the top address,
//               pulses task_done and waits out the buffer drain.
// Revision    : 1.0 - initial release
// ============================================================================
module rbb_result_packer
    import rbb_pkg::*;
#(
    parameter int RBB_ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int RBB_DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int RES_WIDTH      = c_DEF_RES_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      res_valid,
    input  logic [RES_WIDTH-1:0]      res_data,
    input  logic                      res_last,
    output logic                      res_ready,
    input  logic                      rbb_full,
    output logic                      WrEn,
    output logic [RBB_ADDR_WIDTH-1:0] WrAddr,
    output logic [RBB_DATA_WIDTH-1:0] WrDin,
    output logic                      task_done,
    output logic [15:0]               batch_cnt
);

    localparam int                        c_LINES        = rbbNumLines(RBB_ADDR_WIDTH);
    localparam logic [RBB_ADDR_WIDTH-1:0] c_SPLIT_IDX    = RBB_ADDR_WIDTH'(c_LINES - 2);
    localparam logic [RBB_ADDR_WIDTH-1:0] c_TRAILER_ADDR = RBB_ADDR_WIDTH'(c_LINES - 1);

    logic [c_STATE_W-1:0]      r_state;
    logic [c_STATE_W-1:0]      w_stateNext;
    logic                      r_resReady;
    logic                      r_endPending;
    logic                      r_split;
    logic [RBB_ADDR_WIDTH-1:0] r_lineIdx;
    logic [c_CNT_W-1:0]        r_resCnt;
    logic [15:0]               r_batchCnt;

    logic                      w_accept;
    logic                      w_lineComplete;
    logic                      w_lineValid;
    logic [RBB_DATA_WIDTH-1:0] w_lineData;
    logic                      w_closeBatch;
    logic                      w_wrLine;
    logic                      w_wrTrailer;
    logic                      w_taskDone;
    logic [RBB_DATA_WIDTH-1:0] w_trailer;

    assign w_accept = res_valid && r_resReady;

    // The batch ends on the last word or when the second-to-top line fills (top line holds the trailer)
    assign w_closeBatch = w_lineComplete && (res_last || (r_lineIdx == c_SPLIT_IDX));

    rbb_line_assembler #(
        .RBB_DATA_WIDTH (RBB_DATA_WIDTH),
        .RES_WIDTH      (RES_WIDTH)
    ) u_assembler (
        .clk            (clk),
        .rst            (reset),
        .i_clear        (r_state == c_ST_WAIT_DRAIN),
        .i_accept       (w_accept),
        .i_resData      (res_data),
        .i_resLast      (res_last),
        .o_lineComplete (w_lineComplete),
        .o_lineValid    (w_lineValid),
        .o_lineData     (w_lineData)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_WAIT_DRAIN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; FILL is held until the closing data line has been written
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_WAIT_DRAIN: if (!rbb_full) w_stateNext = c_ST_FILL;
            c_ST_FILL:       if (r_endPending && w_lineValid) w_stateNext = c_ST_TRAILER;
            c_ST_TRAILER:    w_stateNext = c_ST_DONE;
            c_ST_DONE:       w_stateNext = c_ST_WAIT_FULL;
            c_ST_WAIT_FULL:  if (rbb_full) w_stateNext = c_ST_WAIT_DRAIN;
            default:         w_stateNext = c_ST_WAIT_DRAIN;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_wrLine    = 1'b0;
        w_wrTrailer = 1'b0;
        w_taskDone  = 1'b0;
        case (r_state)
            c_ST_FILL:    w_wrLine    = w_lineValid;
            c_ST_TRAILER: w_wrTrailer = 1'b1;
            c_ST_DONE:    w_taskDone  = 1'b1;
            default:      ;
        endcase
    end

    // Ready is registered: open in FILL until the closing word of the batch is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resReady <= 1'b0;
        end else begin
            r_resReady <= (w_stateNext == c_ST_FILL) && !r_endPending && !w_closeBatch;
        end
    end

    // Batch-close flag: remembers that the line in flight is the last one of this batch
    always_ff @(posedge clk) begin
        if (reset || (r_state != c_ST_FILL)) begin
            r_endPending <= 1'b0;
        end else if (w_closeBatch) begin
            r_endPending <= 1'b1;
        end
    end

    // Per-batch counters: line index, saturating word count, split marker
    always_ff @(posedge clk) begin
        if (reset || (r_state == c_ST_WAIT_DRAIN)) begin
            r_lineIdx <= '0;
            r_resCnt  <= '0;
            r_split   <= 1'b0;
        end else begin
            if (w_accept && (r_resCnt != '1)) begin
                r_resCnt <= r_resCnt + 32'd1;
            end
            if (w_wrLine) begin
                r_lineIdx <= r_lineIdx + RBB_ADDR_WIDTH'(1);
            end
            if (w_closeBatch && !res_last) begin
                r_split <= 1'b1;
            end
        end
    end

    // Completed-batch counter, free-running with wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_batchCnt <= '0;
        end else if (w_taskDone) begin
            r_batchCnt <= r_batchCnt + 16'd1;
        end
    end

    // Trailer line: lines written, accepted word count, split flag
    always_comb begin
        w_trailer                                = '0;
        w_trailer[c_LINES_LSB +: c_LINES_W]      = c_LINES_W'(r_lineIdx);
        w_trailer[c_CNT_LSB +: c_CNT_W]          = r_resCnt;
        w_trailer[c_SPLIT_BIT]                   = r_split;
    end

    // Write mux; a high Full always blocks the BRAM port so a drain is never corrupted
    always_comb begin
        WrEn   = (w_wrLine || w_wrTrailer) && !rbb_full;
        WrAddr = '0;
        WrDin  = '0;
        if (w_wrTrailer) begin
            WrAddr = c_TRAILER_ADDR;
            WrDin  = w_trailer;
        end else if (w_wrLine) begin
            WrAddr = r_lineIdx;
            WrDin  = w_lineData;
        end
    end

    assign res_ready = r_resReady;
    assign task_done = w_taskDone;
    assign batch_cnt = r_batchCnt;

endmodule
`default_nettype wire

// File: tb/tb_rbb_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbb_result_packer
// Description : Directed self-checking bench for rbb_result_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbb_result_packer;

    localparam int AW  = 8;
    localparam int DW  = 512;
    localparam int RW  = 64;
    localparam int WPL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          res_valid;
    logic [RW-1:0] res_data;
    logic          res_last;
    logic          res_ready;
    logic          rbb_full;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrDin;
    logic          task_done;
    logic [15:0]   batch_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int illegalWr = 0;

    logic [AW-1:0] wAddr[$];
    logic [DW-1:0] wData[$];
    int            wCyc[$];
    int            doneCyc[$];

    rbb_result_packer #(
        .RBB_ADDR_WIDTH (AW),
        .RBB_DATA_WIDTH (DW),
        .RES_WIDTH      (RW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_last  (res_last),
        .res_ready (res_ready),
        .rbb_full  (rbb_full),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrDin     (WrDin),
        .task_done (task_done),
        .batch_cnt (batch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and task_done log, sampled mid-cycle
    always @(negedge clk) begin
        if (WrEn) begin
            wAddr.push_back(WrAddr);
            wData.push_back(WrDin);
            wCyc.push_back(cyc);
            if (rbb_full) illegalWr++;
        end
        if (task_done) doneCyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkW(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] logData(input int i);
        if (i < wData.size()) return wData[i];
        return '0;
    endfunction

    function automatic logic [AW-1:0] logAddr(input int i);
        if (i < wAddr.size()) return wAddr[i];
        return '0;
    endfunction

    function automatic int logCyc(input int i);
        if (i < wCyc.size()) return wCyc[i];
        return -1;
    endfunction

    // Expected data line: n words base, base+1, ... in lanes 0.., zero above
    function automatic logic [DW-1:0] mkLine(input int base, input int n);
        logic [DW-1:0] v = '0;
        for (int l = 0; l < WPL; l++) begin
            if (l < n) v[l*RW +: RW] = RW'(base + l);
        end
        return v;
    endfunction

    // Expected trailer line
    function automatic logic [DW-1:0] mkTrailer(input int lines, input int cnt, input bit split);
        logic [DW-1:0] v = '0;
        v[15:0]  = 16'(lines);
        v[47:16] = 32'(cnt);
        v[48]    = split;
        return v;
    endfunction

    function automatic void clearLog();
        wAddr.delete();
        wData.delete();
        wCyc.delete();
        doneCyc.delete();
    endfunction

    // Offer n words base.. with valid held; bounded by a cycle budget
    task automatic sendWords(input string tag, input int n, input int base, input bit withLast);
        int  sent  = 0;
        int  guard = 0;
        logic acc;
        while (sent < n && guard < 2 * n + 100) begin
            res_valid = 1'b1;
            res_data  = RW'(base + sent);
            res_last  = withLast && (sent == n - 1);
            acc       = res_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            guard++;
        end
        res_valid = 1'b0;
        res_last  = 1'b0;
        chk(tag, sent, n);
    endtask

    task automatic waitDone(input string tag);
        int n    = 0;
        bit seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (task_done) seen = 1;
        end
        chk(tag, seen, 1);
    endtask

    // Called right after task_done: emulate a drain of n cycles
    task automatic drain(input string tag, input int n, input bit holdValid);
        int rdy = 0;
        @(posedge clk); #1;
        rbb_full  = 1'b1;
        res_valid = holdValid;
        res_data  = 64'hDEAD;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (res_ready) rdy++;
        end
        chk({tag, "_ready_during_full"}, rdy, 0);
        rbb_full = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ready_after_full"}, res_ready, 1);
        res_valid = 1'b0;
    endtask

    initial begin
        int bad;
        reset     = 1'b1;
        rbb_full  = 1'b1;
        res_valid = 1'b0;
        res_data  = '0;
        res_last  = 1'b0;

        // 1. Reset with a drain in flight
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_ready", res_ready, 0);
            chk("rst_wren", WrEn, 0);
        end
        chk("rst_done", task_done, 0);
        chk("rst_batch", batch_cnt, 0);
        chk("rst_addr", WrAddr, 0);
        chkW("rst_din", WrDin, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("waitdrain_ready", res_ready, 0);
        rbb_full = 1'b0;
        @(posedge clk); #1;
        chk("fill_ready", res_ready, 1);

        // 2. Two full lines, last on word 16
        clearLog();
        sendWords("b1_send", 16, 1, 1);
        waitDone("b1_done");
        // 5. Long drain with valid held
        drain("b1", 256, 1);
        chk("b1_batch", batch_cnt, 1);
        chk("b1_nwr", wAddr.size(), 3);
        chk("b1_a0", logAddr(0), 0);
        chkW("b1_d0", logData(0), mkLine(1, 8));
        chk("b1_a1", logAddr(1), 1);
        chkW("b1_d1", logData(1), mkLine(9, 8));
        chk("b1_a2", logAddr(2), 255);
        chkW("b1_trl", logData(2), mkTrailer(2, 16, 0));
        chk("b1_ndone", doneCyc.size(), 1);
        chk("b1_done_gap", (doneCyc.size() > 0) ? doneCyc[0] - logCyc(2) : -1, 1);
        chk("b1_b2b", logCyc(1) - logCyc(0), 8);

        // 3. Short batch, partial line
        clearLog();
        sendWords("b2_send", 3, 'hA0, 1);
        waitDone("b2_done");
        drain("b2", 4, 0);
        chk("b2_batch", batch_cnt, 2);
        chk("b2_nwr", wAddr.size(), 2);
        chk("b2_a0", logAddr(0), 0);
        chkW("b2_d0", logData(0), mkLine('hA0, 3));
        chk("b2_a1", logAddr(1), 255);
        chkW("b2_trl", logData(1), mkTrailer(1, 3, 0));

        // 4. Split batch: 255 lines, then remainder in the next batch
        clearLog();
        sendWords("b3_send", 255 * 8, 'h100, 0);
        waitDone("b3_done");
        chk("b3_nwr", wAddr.size(), 256);
        bad = 0;
        for (int k = 0; k < 255; k++) begin
            if (logAddr(k) !== AW'(k)) bad++;
            if (logData(k) !== mkLine('h100 + 8 * k, 8)) bad++;
        end
        chk("b3_lines_bad", bad, 0);
        chk("b3_atrl", logAddr(255), 255);
        chkW("b3_trl", logData(255), mkTrailer(255, 2040, 1));
        drain("b3", 4, 0);
        clearLog();
        sendWords("b4_send", 5, 'h100 + 2040, 1);
        waitDone("b4_done");
        drain("b4", 4, 0);
        chk("b4_batch", batch_cnt, 4);
        chk("b4_nwr", wAddr.size(), 2);
        chk("b4_a0", logAddr(0), 0);
        chkW("b4_d0", logData(0), mkLine('h100 + 2040, 5));
        chkW("b4_trl", logData(1), mkTrailer(1, 5, 0));

        // 6. Reset in the middle of a fill
        clearLog();
        sendWords("b5_send", 4, 'h500, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_ready", res_ready, 0);
        chk("midrst_batch", batch_cnt, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready_back", res_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("midrst_nwr", wAddr.size(), 0);
        chk("midrst_ndone", doneCyc.size(), 0);
        sendWords("b6_send", 2, 'h600, 1);
        waitDone("b6_done");
        drain("b6", 4, 0);
        chk("b6_batch", batch_cnt, 1);
        chk("b6_nwr", wAddr.size(), 2);
        chk("b6_a0", logAddr(0), 0);
        chkW("b6_d0", logData(0), mkLine('h600, 2));
        chkW("b6_trl", logData(1), mkTrailer(1, 2, 0));

        chk("wr_while_full", illegalWr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
